// File: rtl/uart_rx_fifo.sv
// Receive-side frame FIFO for the UART, clocked at 16x baud.
// Edge-detects the receive strobe, buffers frames, and flags drops on overflow.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk_16bd,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         frame_in,
    input  logic                     frame_valid_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             prev_q, prev_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic wr, rd_acc, wr_acc, ovf_set;

    always_comb begin
        wr      = frame_valid_in & ~prev_q;
        rd_acc  = rd_en & (count_q != '0);
        // a read in the same cycle frees the slot a full FIFO needs
        wr_acc  = wr & ((count_q != DEPTH_C) | rd_acc);
        ovf_set = wr & ~wr_acc;

        prev_d     = frame_valid_in;
        wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = rd_acc;

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (ovf_set)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk_16bd) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= frame_in;
    end

    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            prev_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: reads push hand-computed frames,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_uart_rx_fifo;

    logic       clk_16bd;
    logic       rst;
    logic [8:0] frame_in;
    logic       frame_valid_in;
    logic       rd_en;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       clr_overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [8:0] exp_q [$];

    uart_rx_fifo #(.DEPTH(8), .WIDTH(9)) dut (
        .clk_16bd       (clk_16bd),
        .rst            (rst),
        .frame_in       (frame_in),
        .frame_valid_in (frame_valid_in),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    initial clk_16bd = 1'b0;
    always #5 clk_16bd = ~clk_16bd;

    always @(negedge clk_16bd) begin
        if (!rst && rd_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: got rd_data=%h, wanted no read", rd_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, wanted %h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_16bd);
        #1;
    endtask

    task automatic wr1(input logic [8:0] f);
        frame_valid_in = 1'b1;
        frame_in       = f;
        tick();
        frame_valid_in = 1'b0;
        tick();
    endtask

    task automatic rd1(input logic [8:0] e);
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        frame_in       = '0;
        frame_valid_in = 1'b0;
        rd_en          = 1'b0;
        clr_overflow   = 1'b0;
        tick();
        tick();
        chk("rst_count", 9'(count), 9'd0);
        chk("rst_empty", 9'(empty), 9'd1);
        chk("rst_full", 9'(full), 9'd0);
        chk("rst_overflow", 9'(overflow), 9'd0);
        chk("rst_rd_valid", 9'(rd_valid), 9'd0);
        chk("rst_rd_data", rd_data, 9'h000);
        rst = 1'b0;
        tick();

        // three frames in, three out
        wr1(9'h155);
        wr1(9'h0AA);
        wr1(9'h1FF);
        chk("basic_count", 9'(count), 9'd3);
        rd1(9'h155);
        rd1(9'h0AA);
        rd1(9'h1FF);
        chk("basic_empty", 9'(empty), 9'd1);
        tick();
        chk("basic_pulse", 9'(rd_valid), 9'd0);

        // long strobe writes once
        frame_valid_in = 1'b1;
        frame_in       = 9'h042;
        repeat (20) tick();
        frame_valid_in = 1'b0;
        tick();
        chk("strobe_count", 9'(count), 9'd1);
        rd1(9'h042);
        chk("strobe_empty", 9'(empty), 9'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_valid", 9'(rd_valid), 9'd0);
        chk("empty_rd_hold", rd_data, 9'h042);

        // overflow on ninth frame
        for (int i = 0; i < 9; i++) wr1(9'h100 + 9'(i));
        chk("ovf_full", 9'(full), 9'd1);
        chk("ovf_count", 9'(count), 9'd8);
        chk("ovf_flag", 9'(overflow), 9'd1);
        for (int i = 0; i < 8; i++) rd1(9'h100 + 9'(i));
        chk("ovf_drain_empty", 9'(empty), 9'd1);
        chk("ovf_sticky", 9'(overflow), 9'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clear", 9'(overflow), 9'd0);

        // full FIFO, simultaneous write and read
        for (int i = 0; i < 8; i++) wr1(9'h010 + 9'(i));
        frame_valid_in = 1'b1;
        frame_in       = 9'h0F0;
        rd_en          = 1'b1;
        exp_q.push_back(9'h010);
        tick();
        frame_valid_in = 1'b0;
        rd_en          = 1'b0;
        chk("fullrw_count", 9'(count), 9'd8);
        chk("fullrw_ovf", 9'(overflow), 9'd0);
        for (int i = 1; i < 8; i++) rd1(9'h010 + 9'(i));
        rd1(9'h0F0);
        chk("fullrw_empty", 9'(empty), 9'd1);

        // overflow set beats clear in the same cycle
        for (int i = 0; i < 8; i++) wr1(9'h020 + 9'(i));
        frame_valid_in = 1'b1;
        frame_in       = 9'h0EE;
        clr_overflow   = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        clr_overflow   = 1'b0;
        tick();
        chk("set_wins", 9'(overflow), 9'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        for (int i = 0; i < 8; i++) rd1(9'h020 + 9'(i));
        chk("set_wins_clear", 9'(overflow), 9'd0);

        // empty FIFO: write and read together, no fall-through
        frame_valid_in = 1'b1;
        frame_in       = 9'h033;
        rd_en          = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        rd_en          = 1'b0;
        chk("nofall_valid", 9'(rd_valid), 9'd0);
        chk("nofall_count", 9'(count), 9'd1);
        rd1(9'h033);
        chk("nofall_empty", 9'(empty), 9'd1);

        // pointer wrap
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) wr1(9'h040 + 9'(r * 8 + k));
            for (int k = 0; k < 5; k++) rd1(9'h040 + 9'(r * 8 + k));
        end
        chk("wrap_empty", 9'(empty), 9'd1);

        // reset mid-stream
        wr1(9'h1A0);
        wr1(9'h1A1);
        wr1(9'h1A2);
        chk("pre_rst_count", 9'(count), 9'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 9'(count), 9'd0);
        frame_valid_in = 1'b1;
        frame_in       = 9'h123;
        tick();
        chk("mid_rst_empty", 9'(empty), 9'd1);
        chk("mid_rst_ovf", 9'(overflow), 9'd0);
        rst = 1'b0;
        tick();
        frame_valid_in = 1'b0;
        tick();
        chk("post_rst_count", 9'(count), 9'd1);
        rd1(9'h123);
        tick();
        chk("post_rst_empty", 9'(empty), 9'd1);

        tick();
        chk("scoreboard_drained", 9'(exp_q.size()), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
